// File: rtl/flag_branch_unit.sv
// NZCV capture and branch resolution between EX and PC select.
// Define FLAG_FWD_EN to bypass EX flags into B.cond and remove the stall.
module flag_branch_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ex_valid,
   input  logic             ex_set_flags,
   input  logic             ex_negative,
   input  logic             ex_zero,
   input  logic             ex_overflow,
   input  logic             ex_carry_out,
   input  logic             br_req,
   input  logic             br_is_cb,
   input  logic             br_cb_nz,
   input  logic             br_cb_zero,
   input  logic [3:0]       br_cond,
   input  logic             flush,
   output logic             br_valid,
   output logic             br_taken,
   output logic             stall,
   output logic [3:0]       nzcv,
   output logic [CNT_W-1:0] taken_count,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [3:0]       r_nzcv;
   logic             r_br_valid;
   logic             r_br_taken;
   logic [CNT_W-1:0] r_taken_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic       w_ex_wr;
   logic       w_flag_we;
   logic [3:0] w_ex_nzcv;
   logic [3:0] w_flags;
   logic       w_need_stall;
   logic       w_base;
   logic       w_inv;
   logic       w_cond_ok;
   logic       w_taken;
   logic       w_resolve;

   assign w_ex_wr   = ex_valid & ex_set_flags;
   assign w_flag_we = w_ex_wr & ~flush;
   assign w_ex_nzcv = {ex_negative, ex_zero,
                       ex_carry_out, ex_overflow};

`ifdef FLAG_FWD_EN
   assign w_flags      = w_ex_wr ? w_ex_nzcv : r_nzcv;
   assign w_need_stall = 1'b0;
`else
   assign w_flags      = r_nzcv;
   assign w_need_stall = br_req & ~br_is_cb & w_ex_wr;
`endif

   // Odd codes invert the even base, except 111x which is always taken.
   always_comb begin
      w_base = 1'b1;
      unique case (br_cond[3:1])
         3'b000: w_base = w_flags[2];
         3'b001: w_base = w_flags[1];
         3'b010: w_base = w_flags[3];
         3'b011: w_base = w_flags[0];
         3'b100: w_base = w_flags[1] & ~w_flags[2];
         3'b101: w_base = w_flags[3] == w_flags[0];
         3'b110: w_base = ~w_flags[2] &
                          (w_flags[3] == w_flags[0]);
         3'b111: w_base = 1'b1;
      endcase
   end

   assign w_inv     = br_cond[0] & (br_cond[3:1] != 3'b111);
   assign w_cond_ok = w_base ^ w_inv;
   assign w_taken   = br_is_cb ? (br_cb_zero ^ br_cb_nz)
                               : w_cond_ok;

   always_comb begin
      w_state_nx = r_state;
      w_resolve  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (br_req && !flush) begin
               if (w_need_stall) w_state_nx = HOLD;
               else              w_resolve  = 1'b1;
            end
         end
         HOLD: begin
            w_state_nx = IDLE;
            w_resolve  = ~flush;
         end
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_nzcv      <= '0;
         r_br_valid  <= 1'b0;
         r_br_taken  <= 1'b0;
         r_taken_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_br_valid <= w_resolve;
         r_br_taken <= w_resolve & w_taken;
         if (w_flag_we)
            r_nzcv <= w_ex_nzcv;
         if (w_resolve & w_taken)
            r_taken_cnt <= r_taken_cnt + CNT_W'(1);
         if (r_state == HOLD)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign br_valid    = r_br_valid;
   assign br_taken    = r_br_taken;
   assign stall       = (r_state == HOLD);
   assign nzcv        = r_nzcv;
   assign taken_count = r_taken_cnt;
   assign stall_count = r_stall_cnt;

endmodule
